// File: rtl/pmem_line_responder.sv
// Line-granular memory responder for the 128-bit physical line interface.
// Optional request-protocol checker enabled by defining PMEM_PROTOCOL_CHECK_EN.
module pmem_line_responder #(
  parameter int LINE_IDX_BITS = 8,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         physical_read,
  input  logic         physical_write,
  input  logic [15:0]  physical_address,
  input  logic [127:0] physical_wdata,
  output logic         physical_resp,
  output logic [127:0] physical_rdata,
  output logic         proto_err
);

  localparam int DEPTH = 1 << LINE_IDX_BITS;
  localparam logic [7:0] RD_LOAD = 8'(READ_LATENCY - 1);
  localparam logic [7:0] WR_LOAD = 8'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, TURN} state_t;

  state_t                   state, state_nxt;
  logic [7:0]               counter, counter_nxt;
  logic                     op_write, op_write_nxt;
  logic [LINE_IDX_BITS-1:0] idx, idx_nxt;
  logic [127:0]             wdata_q, wdata_nxt;

  logic                     commit_write, commit_read;
  logic [LINE_IDX_BITS-1:0] commit_idx;
  logic [127:0]             commit_wdata;

  logic [127:0]             mem [DEPTH];

  logic [LINE_IDX_BITS-1:0] req_idx;
  logic                     unused_addr;

  // Low nibble and high aliasing bits select nothing; fold them away explicitly.
  assign req_idx     = physical_address[LINE_IDX_BITS+3:4];
  assign unused_addr = ^physical_address;

  assign physical_resp = (state == RESP);

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    counter_nxt  = counter;
    op_write_nxt = op_write;
    idx_nxt      = idx;
    wdata_nxt    = wdata_q;
    commit_write = 1'b0;
    commit_read  = 1'b0;
    commit_idx   = idx;
    commit_wdata = wdata_q;

    unique case (state)
      IDLE: begin
        if (physical_write) begin
          op_write_nxt = 1'b1;
          idx_nxt      = req_idx;
          wdata_nxt    = physical_wdata;
          counter_nxt  = WR_LOAD;
          if (WR_LOAD == 8'd0) begin
            // Single-cycle latency commits straight from the live inputs.
            state_nxt    = RESP;
            commit_write = 1'b1;
            commit_idx   = req_idx;
            commit_wdata = physical_wdata;
          end else begin
            state_nxt = WAIT;
          end
        end else if (physical_read) begin
          op_write_nxt = 1'b0;
          idx_nxt      = req_idx;
          counter_nxt  = RD_LOAD;
          if (RD_LOAD == 8'd0) begin
            state_nxt   = RESP;
            commit_read = 1'b1;
            commit_idx  = req_idx;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        counter_nxt = counter - 8'd1;
        if (counter == 8'd1) begin
          state_nxt    = RESP;
          commit_write = op_write;
          commit_read  = !op_write;
        end
      end
      RESP:    state_nxt = TURN;
      TURN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      counter        <= 8'd0;
      op_write       <= 1'b0;
      idx            <= '0;
      wdata_q        <= '0;
      physical_rdata <= '0;
    end else begin
      state    <= state_nxt;
      counter  <= counter_nxt;
      op_write <= op_write_nxt;
      idx      <= idx_nxt;
      wdata_q  <= wdata_nxt;
      if (commit_read) physical_rdata <= mem[commit_idx];
    end
  end

  // NOTE: the array has no reset; it maps onto block RAM and its contents
  // must survive rst_n.
  always_ff @(posedge clk) begin
    if (commit_write) mem[commit_idx] <= commit_wdata;
  end

`ifdef PMEM_PROTOCOL_CHECK_EN
  logic [15:0] addr_q;
  logic        after_turn;
  logic        err_nxt;
  logic        op_req;

  // Level of the request line belonging to the op in flight (or just completed).
  assign op_req = op_write ? physical_write : physical_read;

  always_comb begin
    err_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (physical_read && physical_write) err_nxt = 1'b1;
        if (after_turn && op_req && (physical_address == addr_q)) err_nxt = 1'b1;
      end
      WAIT: begin
        if (!op_req) err_nxt = 1'b1;
        if (physical_address != addr_q) err_nxt = 1'b1;
        if (op_write && (physical_wdata != wdata_q)) err_nxt = 1'b1;
      end
      default: err_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      after_turn <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      if ((state == IDLE) && (physical_read || physical_write)) addr_q <= physical_address;
      after_turn <= (state == TURN);
      if (err_nxt) proto_err <= 1'b1;
    end
  end
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_line_responder.sv
// Self-checking bench for pmem_line_responder: table-driven ops on a default
// latency instance plus hand-written corner sequences on a latency-1 instance.
module tb_pmem_line_responder;

  localparam int LAT = 4;

  localparam logic [127:0] L1   = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
  localparam logic [127:0] L2   = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEDC_BA98;
  localparam logic [127:0] A5   = {16{8'hA5}};
  localparam logic [127:0] BH   = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
  localparam logic [127:0] OLD  = 128'hC0DE_C0DE_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] NEW  = 128'hBAD0_BAD0_7777_8888_9999_AAAA_BBBB_CCCC;
  localparam logic [127:0] FAST = 128'h0F0F_F0F0_3C3C_C3C3_5A5A_A5A5_6969_9696;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         physical_read, physical_write;
  logic [15:0]  physical_address;
  logic [127:0] physical_wdata;
  logic         physical_resp;
  logic [127:0] physical_rdata;
  logic         proto_err;

  logic         f_read, f_write;
  logic [15:0]  f_address;
  logic [127:0] f_wdata;
  logic         f_resp;
  logic [127:0] f_rdata;
  logic         f_proto_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
    logic [127:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic         is_read;
    logic [127:0] rdata;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];

  always #5 clk = ~clk;

  pmem_line_responder u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .physical_read    (physical_read),
    .physical_write   (physical_write),
    .physical_address (physical_address),
    .physical_wdata   (physical_wdata),
    .physical_resp    (physical_resp),
    .physical_rdata   (physical_rdata),
    .proto_err        (proto_err)
  );

  pmem_line_responder #(.READ_LATENCY(1), .WRITE_LATENCY(1)) u_dut_fast (
    .clk              (clk),
    .rst_n            (rst_n),
    .physical_read    (f_read),
    .physical_write   (f_write),
    .physical_address (f_address),
    .physical_wdata   (f_wdata),
    .physical_resp    (f_resp),
    .physical_rdata   (f_rdata),
    .proto_err        (f_proto_err)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Called on a negedge with the DUT idle; returns on a negedge with it idle again.
  task automatic run_op(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [127:0] wd, input logic [127:0] exp_rd, input string name);
    exp_t e;
    exp_t got;
    int   n;
    e.is_read = rd && !wr;
    e.rdata   = exp_rd;
    sb.push_back(e);
    physical_read    = rd;
    physical_write   = wr;
    physical_address = a;
    physical_wdata   = wd;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    while (!physical_resp && n < 300) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check({name, " latency"}, 128'(n), 128'(LAT));
    if (physical_resp && sb.size() > 0) begin
      got = sb.pop_front();
      if (got.is_read) check({name, " rdata"}, physical_rdata, got.rdata);
    end
    physical_read  = 1'b0;
    physical_write = 1'b0;
    @(negedge clk);
    check({name, " resp width"}, 128'(physical_resp), 128'(0));
    @(negedge clk);
  endtask

  initial begin
    logic exp_err;

    vecs[0] = '{1'b0, 1'b1, 16'h0040, L1,  '0};
    vecs[1] = '{1'b1, 1'b0, 16'h0040, '0,  L1};
    vecs[2] = '{1'b0, 1'b1, 16'h0080, L2,  '0};
    vecs[3] = '{1'b1, 1'b0, 16'h0080, '0,  L2};
    vecs[4] = '{1'b0, 1'b1, 16'h0030, A5,  '0};
    vecs[5] = '{1'b1, 1'b0, 16'h1030, '0,  A5};
    vecs[6] = '{1'b1, 1'b1, 16'h0100, BH,  '0};
    vecs[7] = '{1'b1, 1'b0, 16'h0100, '0,  BH};
    vecs[8] = '{1'b0, 1'b1, 16'h0200, OLD, '0};

`ifdef PMEM_PROTOCOL_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif

    rst_n = 1'b0;
    physical_read = 1'b0; physical_write = 1'b0; physical_address = '0; physical_wdata = '0;
    f_read = 1'b0; f_write = 1'b0; f_address = '0; f_wdata = '0;

    #2;
    check("reset resp", 128'(physical_resp), 128'(0));
    check("reset rdata", physical_rdata, '0);
    check("reset proto_err", 128'(proto_err), 128'(0));
    check("reset fast resp", 128'(f_resp), 128'(0));
    check("reset fast rdata", f_rdata, '0);

    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata,
             $sformatf("vec%0d", i));
      if (i == 2) check("rdata held across write", physical_rdata, L1);
      if (i == 6) check("proto_err after read+write", 128'(proto_err), 128'(exp_err));
    end

    // Reset two clocks after accepting a write: the write must never land.
    physical_write   = 1'b1;
    physical_address = 16'h0200;
    physical_wdata   = NEW;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n          = 1'b0;
    physical_write = 1'b0;
    #1;
    check("mid-op reset resp", 128'(physical_resp), 128'(0));
    check("mid-op reset proto_err", 128'(proto_err), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(1'b1, 1'b0, 16'h0200, '0, OLD, "read after aborted write");

    // Latency-1 instance: write, then hold read high across several responses.
    f_write   = 1'b1;
    f_address = 16'h0050;
    f_wdata   = FAST;
    @(negedge clk);
    check("fast write resp", 128'(f_resp), 128'(1));
    f_write = 1'b0;
    @(negedge clk);
    check("fast write turn", 128'(f_resp), 128'(0));
    @(negedge clk);
    f_read = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("fast held read cycle %0d resp", i), 128'(f_resp), 128'((i % 3) == 0));
      if ((i % 3) == 0) check($sformatf("fast held read cycle %0d rdata", i), f_rdata, FAST);
    end
    f_read = 1'b0;
    check("fast proto_err after held read", 128'(f_proto_err), 128'(exp_err));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
